// File: rtl/bpi_access_arbiter.sv
// Two-requester arbiter for the shared BPI flash command interface, with a stall watchdog.
// Defining BPI_ARB_RR_EN replaces fixed A-priority tie-break with round-robin.
module bpi_access_arbiter #(
    parameter int TO_W      = 16,
    parameter int TO_CYCLES = 50000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        A_REQ,
    input  logic [22:0] A_ADDR,
    input  logic [15:0] A_CMD_DATA,
    input  logic [1:0]  A_OP,
    input  logic        A_EXECUTE,
    output logic        A_GNT,
    input  logic        U_REQ,
    input  logic [22:0] U_ADDR,
    input  logic [15:0] U_CMD_DATA,
    input  logic [1:0]  U_OP,
    input  logic        U_EXECUTE,
    output logic        U_GNT,
    input  logic        BUSY,
    output logic [22:0] BPI_ADDR,
    output logic [15:0] BPI_CMD_DATA,
    output logic [1:0]  BPI_OP,
    output logic        BPI_EXECUTE,
    output logic        ARB_ABORT,
    output logic [1:0]  ARB_OWNER
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_OWN_A = 2'b01,
        S_OWN_U = 2'b10,
        S_DRAIN = 2'b11
    } state_e;

    localparam bit              WD_EN   = (TO_CYCLES != 0);
    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TO_CYCLES - 1);

    generate
        if (TO_CYCLES < 0 || (TO_W < 31 && TO_CYCLES >= (1 << TO_W))) begin : g_cfg_check
            $error("bpi_access_arbiter: TO_CYCLES does not fit in TO_W bits");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              a_rearm_q, a_rearm_d;
    logic              u_rearm_q, u_rearm_d;
    logic              abort_q, abort_d;
    logic [22:0]       addr_hold_q;
    logic [15:0]       data_hold_q;
    logic              own;
    logic              owner_req;
    logic              wd_expire;
    logic              a_elig, u_elig, pick_a;
`ifdef BPI_ARB_RR_EN
    logic              last_u_q, last_u_d;
`endif

    assign own = (state_q == S_OWN_A) || (state_q == S_OWN_U);

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_rearm_q   <= 1'b1;
            u_rearm_q   <= 1'b1;
            abort_q     <= 1'b0;
            addr_hold_q <= '0;
            data_hold_q <= '0;
`ifdef BPI_ARB_RR_EN
            last_u_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_rearm_q <= a_rearm_d;
            u_rearm_q <= u_rearm_d;
            abort_q   <= abort_d;
`ifdef BPI_ARB_RR_EN
            last_u_q  <= last_u_d;
`endif
            if (own) begin
                addr_hold_q <= BPI_ADDR;
                data_hold_q <= BPI_CMD_DATA;
            end
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        abort_d   = 1'b0;
        a_rearm_d = a_rearm_q | ~A_REQ;
        u_rearm_d = u_rearm_q | ~U_REQ;
        owner_req = (state_q == S_OWN_A) ? A_REQ : U_REQ;
        wd_expire = WD_EN && own && !BPI_EXECUTE && (cnt_q == WD_LAST);
        a_elig    = A_REQ && a_rearm_q;
        u_elig    = U_REQ && u_rearm_q;
`ifdef BPI_ARB_RR_EN
        last_u_d  = last_u_q;
        pick_a    = a_elig && (!u_elig || last_u_q);
`else
        pick_a    = a_elig;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (pick_a) begin
                    state_d = S_OWN_A;
`ifdef BPI_ARB_RR_EN
                    last_u_d = 1'b0;
`endif
                end else if (u_elig) begin
                    state_d = S_OWN_U;
`ifdef BPI_ARB_RR_EN
                    last_u_d = 1'b1;
`endif
                end
            end
            S_OWN_A, S_OWN_U: begin
                if (!owner_req) begin
                    state_d = S_DRAIN;
                end else if (wd_expire) begin
                    // Reclaim from a stalled owner; it must drop REQ before it can win again.
                    state_d = S_DRAIN;
                    abort_d = 1'b1;
                    if (state_q == S_OWN_A) a_rearm_d = 1'b0;
                    else                    u_rearm_d = 1'b0;
                end else if (!BPI_EXECUTE) begin
                    cnt_d = (BUSY || (&cnt_q)) ? cnt_q : cnt_q + TO_W'(1);
                end
            end
            S_DRAIN: begin
                if (!BUSY) state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        A_GNT        = (state_q == S_OWN_A);
        U_GNT        = (state_q == S_OWN_U);
        BPI_ADDR     = addr_hold_q;
        BPI_CMD_DATA = data_hold_q;
        BPI_OP       = 2'b00;
        BPI_EXECUTE  = 1'b0;
        ARB_ABORT    = abort_q;
        ARB_OWNER    = state_q;
        case (state_q)
            S_OWN_A: begin
                BPI_ADDR     = A_ADDR;
                BPI_CMD_DATA = A_CMD_DATA;
                BPI_OP       = A_OP;
                BPI_EXECUTE  = A_EXECUTE & ~BUSY;
            end
            S_OWN_U: begin
                BPI_ADDR     = U_ADDR;
                BPI_CMD_DATA = U_CMD_DATA;
                BPI_OP       = U_OP;
                BPI_EXECUTE  = U_EXECUTE & ~BUSY;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bpi_access_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
// Two DUTs share stimulus: one with an 8-cycle watchdog, one with the watchdog disabled.
module tb_bpi_access_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        A_REQ, A_EXECUTE, U_REQ, U_EXECUTE, BUSY;
    logic [22:0] A_ADDR, U_ADDR;
    logic [15:0] A_CMD_DATA, U_CMD_DATA;
    logic [1:0]  A_OP, U_OP;

    logic        d8_a_gnt, d8_u_gnt, d8_exec, d8_abort;
    logic [22:0] d8_addr;
    logic [15:0] d8_data;
    logic [1:0]  d8_op, d8_owner;
    logic        d0_a_gnt, d0_u_gnt, d0_exec, d0_abort;
    logic [22:0] d0_addr;
    logic [15:0] d0_data;
    logic [1:0]  d0_op, d0_owner;

    logic [46:0] obs [2];
    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    bpi_access_arbiter #(.TO_W(16), .TO_CYCLES(8)) u_dut_wd (
        .CLK(CLK), .RST_N(RST_N),
        .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_CMD_DATA(A_CMD_DATA), .A_OP(A_OP),
        .A_EXECUTE(A_EXECUTE), .A_GNT(d8_a_gnt),
        .U_REQ(U_REQ), .U_ADDR(U_ADDR), .U_CMD_DATA(U_CMD_DATA), .U_OP(U_OP),
        .U_EXECUTE(U_EXECUTE), .U_GNT(d8_u_gnt),
        .BUSY(BUSY), .BPI_ADDR(d8_addr), .BPI_CMD_DATA(d8_data), .BPI_OP(d8_op),
        .BPI_EXECUTE(d8_exec), .ARB_ABORT(d8_abort), .ARB_OWNER(d8_owner)
    );

    // Narrow counter so saturation is reached quickly while the watchdog is off.
    bpi_access_arbiter #(.TO_W(4), .TO_CYCLES(0)) u_dut_nt (
        .CLK(CLK), .RST_N(RST_N),
        .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_CMD_DATA(A_CMD_DATA), .A_OP(A_OP),
        .A_EXECUTE(A_EXECUTE), .A_GNT(d0_a_gnt),
        .U_REQ(U_REQ), .U_ADDR(U_ADDR), .U_CMD_DATA(U_CMD_DATA), .U_OP(U_OP),
        .U_EXECUTE(U_EXECUTE), .U_GNT(d0_u_gnt),
        .BUSY(BUSY), .BPI_ADDR(d0_addr), .BPI_CMD_DATA(d0_data), .BPI_OP(d0_op),
        .BPI_EXECUTE(d0_exec), .ARB_ABORT(d0_abort), .ARB_OWNER(d0_owner)
    );

    assign obs[0] = {d8_a_gnt, d8_u_gnt, d8_addr, d8_data, d8_op, d8_exec, d8_abort, d8_owner};
    assign obs[1] = {d0_a_gnt, d0_u_gnt, d0_addr, d0_data, d0_op, d0_exec, d0_abort, d0_owner};

    function automatic logic [46:0] pack(logic ga, logic gu, logic [22:0] a, logic [15:0] d,
                                         logic [1:0] op, logic ex, logic ab, logic [1:0] own);
        return {ga, gu, a, d, op, ex, ab, own};
    endfunction

    // Reference model: owner 0 none, 1 A, 2 U, 3 draining; idle counts quiet cycles.
    typedef struct {
        int          own;
        int          idle;
        bit          ra;
        bit          ru;
        bit          abort;
        bit          last_u;
        logic [22:0] ah;
        logic [15:0] dh;
    } mdl_t;

    mdl_t m [2];

    function automatic int to_of(int k);
        return (k == 0) ? 8 : 0;
    endfunction

    function automatic logic [46:0] mdl_out(mdl_t c);
        logic [22:0] a  = c.ah;
        logic [15:0] d  = c.dh;
        logic [1:0]  op = 2'b00;
        logic        ex = 1'b0;
        if (c.own == 1) begin
            a = A_ADDR; d = A_CMD_DATA; op = A_OP; ex = A_EXECUTE && !BUSY;
        end else if (c.own == 2) begin
            a = U_ADDR; d = U_CMD_DATA; op = U_OP; ex = U_EXECUTE && !BUSY;
        end
        return pack(c.own == 1, c.own == 2, a, d, op, ex, c.abort, 2'(c.own));
    endfunction

    function automatic mdl_t mdl_next(int k);
        mdl_t        c = m[k];
        mdl_t        n = m[k];
        logic [46:0] o;
        bit          pass, ea, eu, req;
        int          win;
        if (!RST_N) begin
            n.own = 0; n.idle = 0; n.ra = 1; n.ru = 1; n.abort = 0; n.last_u = 1;
            n.ah = '0; n.dh = '0;
            return n;
        end
        o       = mdl_out(c);
        pass    = o[3];
        n.abort = 0;
        if (!A_REQ) n.ra = 1;
        if (!U_REQ) n.ru = 1;
        if (c.own == 0) begin
            ea  = A_REQ && c.ra;
            eu  = U_REQ && c.ru;
            win = 0;
`ifdef BPI_ARB_RR_EN
            if (ea && eu) win = c.last_u ? 1 : 2;
`else
            if (ea && eu) win = 1;
`endif
            else if (ea) win = 1;
            else if (eu) win = 2;
            if (win != 0) begin
                n.own = win; n.idle = 0; n.last_u = (win == 2);
            end
        end else if (c.own == 3) begin
            if (!BUSY) n.own = 0;
        end else begin
            n.ah = o[44:22];
            n.dh = o[21:6];
            req  = (c.own == 1) ? A_REQ : U_REQ;
            if (!req) n.own = 3;
            else if (to_of(k) != 0 && !pass && c.idle == to_of(k) - 1) begin
                n.own = 3; n.abort = 1;
                if (c.own == 1) n.ra = 0; else n.ru = 0;
            end else if (pass) n.idle = 0;
            else if (!BUSY) n.idle = c.idle + 1;
        end
        return n;
    endfunction

    always @(posedge CLK) begin
        for (int k = 0; k < 2; k++) m[k] <= mdl_next(k);
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic clear_inputs();
        A_REQ = 0; A_EXECUTE = 0; A_ADDR = '0; A_CMD_DATA = '0; A_OP = '0;
        U_REQ = 0; U_EXECUTE = 0; U_ADDR = '0; U_CMD_DATA = '0; U_OP = '0;
        BUSY  = 0;
    endtask

    task automatic settle();
        clear_inputs();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic [46:0] exp;
        RST_N = 0;
        clear_inputs();
        A_REQ = 1; U_REQ = 1; BUSY = 1; A_ADDR = 23'h12345; U_OP = 2'b11; A_EXECUTE = 1;
        tick(); tick();
        #1;
        exp = '0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: got %h expected %h", k, obs[k], exp);
            end
        end
        clear_inputs();
        RST_N = 1;
        tick();
    endtask

    task automatic test_autoload();
        logic [46:0] exp;
        A_REQ = 1; A_ADDR = 23'h7FC000; A_OP = 2'b10; A_CMD_DATA = 16'h00FF;
        #1;
        exp = pack(0, 0, 23'h0, 16'h0, 2'b00, 0, 0, 2'b00);
        vectors++;
        if (obs[0] !== exp) begin
            miscompares++; $display("FAIL autoload_latency: got %h expected %h", obs[0], exp);
        end
        tick(); #1;
        exp = pack(1, 0, 23'h7FC000, 16'h00FF, 2'b10, 0, 0, 2'b01);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp) begin
                miscompares++; $display("FAIL autoload_grant dut%0d: got %h expected %h", k, obs[k], exp);
            end
        end
        A_EXECUTE = 1; #1;
        exp = pack(1, 0, 23'h7FC000, 16'h00FF, 2'b10, 1, 0, 2'b01);
        vectors++;
        if (obs[0] !== exp) begin
            miscompares++; $display("FAIL autoload_execute: got %h expected %h", obs[0], exp);
        end
        tick(); A_EXECUTE = 0; #1;
        exp = pack(1, 0, 23'h7FC000, 16'h00FF, 2'b10, 0, 0, 2'b01);
        vectors++;
        if (obs[0] !== exp) begin
            miscompares++; $display("FAIL autoload_exec_pulse: got %h expected %h", obs[0], exp);
        end
        A_REQ = 0; tick(); #1;
        exp = pack(0, 0, 23'h7FC000, 16'h00FF, 2'b00, 0, 0, 2'b11);
        vectors++;
        if (obs[0] !== exp) begin
            miscompares++; $display("FAIL autoload_drain: got %h expected %h", obs[0], exp);
        end
        tick(); #1;
        exp = pack(0, 0, 23'h7FC000, 16'h00FF, 2'b00, 0, 0, 2'b00);
        vectors++;
        if (obs[0] !== exp) begin
            miscompares++; $display("FAIL autoload_idle_hold: got %h expected %h", obs[0], exp);
        end
        settle();
    endtask

    task automatic test_arbitration();
        logic [46:0] exp;
        A_ADDR = 23'h123456; A_CMD_DATA = 16'h1111; A_OP = 2'b01;
        U_ADDR = 23'h654321; U_CMD_DATA = 16'h2222; U_OP = 2'b11;
        A_REQ = 1; U_REQ = 1;
        tick(); #1;
        exp = pack(1, 0, 23'h123456, 16'h1111, 2'b01, 0, 0, 2'b01);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp) begin
                miscompares++; $display("FAIL tie_a_wins dut%0d: got %h expected %h", k, obs[k], exp);
            end
        end
        A_REQ = 0; BUSY = 1;
        tick();
        A_ADDR = 23'h000ABC; A_EXECUTE = 1; U_EXECUTE = 1;
        exp = pack(0, 0, 23'h123456, 16'h1111, 2'b00, 0, 0, 2'b11);
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (obs[0] !== exp) begin
                miscompares++; $display("FAIL drain_busy cycle%0d: got %h expected %h", i, obs[0], exp);
            end
            if (i < 3) tick();
        end
        BUSY = 0; A_EXECUTE = 0; U_EXECUTE = 0;
        tick(); #1;
        exp = pack(0, 0, 23'h123456, 16'h1111, 2'b00, 0, 0, 2'b00);
        vectors++;
        if (obs[0] !== exp) begin
            miscompares++; $display("FAIL drain_to_idle: got %h expected %h", obs[0], exp);
        end
        tick(); #1;
        exp = pack(0, 1, 23'h654321, 16'h2222, 2'b11, 0, 0, 2'b10);
        vectors++;
        if (obs[0] !== exp) begin
            miscompares++; $display("FAIL u_after_drain: got %h expected %h", obs[0], exp);
        end
        U_REQ = 0; tick(); tick();
        A_REQ = 1; tick();
        A_REQ = 0; tick(); tick();
        A_REQ = 1; U_REQ = 1;
        tick(); #1;
`ifdef BPI_ARB_RR_EN
        exp = pack(0, 1, 23'h654321, 16'h2222, 2'b11, 0, 0, 2'b10);
`else
        exp = pack(1, 0, 23'h000ABC, 16'h1111, 2'b01, 0, 0, 2'b01);
`endif
        vectors++;
        if (obs[0] !== exp) begin
            miscompares++; $display("FAIL tie_after_a_grant: got %h expected %h", obs[0], exp);
        end
        settle();
    endtask

    task automatic test_exec_gating();
        logic [46:0] exp;
        U_REQ = 1; U_ADDR = 23'h00BEEF; U_CMD_DATA = 16'h9090; U_OP = 2'b01;
        A_ADDR = 23'h7FFFFF; A_OP = 2'b11;
        tick();
        U_EXECUTE = 1; BUSY = 1; #1;
        exp = pack(0, 1, 23'h00BEEF, 16'h9090, 2'b01, 0, 0, 2'b10);
        vectors++;
        if (obs[0] !== exp) begin
            miscompares++; $display("FAIL exec_while_busy: got %h expected %h", obs[0], exp);
        end
        tick();
        BUSY = 0; #1;
        exp = pack(0, 1, 23'h00BEEF, 16'h9090, 2'b01, 1, 0, 2'b10);
        vectors++;
        if (obs[0] !== exp) begin
            miscompares++; $display("FAIL exec_not_busy: got %h expected %h", obs[0], exp);
        end
        tick();
        U_EXECUTE = 0; A_EXECUTE = 1; A_REQ = 1; #1;
        exp = pack(0, 1, 23'h00BEEF, 16'h9090, 2'b01, 0, 0, 2'b10);
        vectors++;
        if (obs[0] !== exp) begin
            miscompares++; $display("FAIL non_owner_ignored: got %h expected %h", obs[0], exp);
        end
        settle();
    endtask

    task automatic test_watchdog();
        logic [46:0] exp;
        U_REQ = 1; U_ADDR = 23'h000055;
        tick();
        for (int k = 0; k <= 8; k++) begin
            #1;
            exp = (k < 8) ? pack(0, 1, 23'h55, 16'h0, 2'b00, 0, 0, 2'b10)
                          : pack(0, 0, 23'h55, 16'h0, 2'b00, 0, 1, 2'b11);
            vectors++;
            if (obs[0] !== exp) begin
                miscompares++; $display("FAIL watchdog_cycle%0d: got %h expected %h", k, obs[0], exp);
            end
            if (k < 8) tick();
        end
        exp = pack(0, 1, 23'h55, 16'h0, 2'b00, 0, 0, 2'b10);
        vectors++;
        if (obs[1] !== exp) begin
            miscompares++; $display("FAIL wd_disabled_keeps: got %h expected %h", obs[1], exp);
        end
        exp = pack(0, 0, 23'h55, 16'h0, 2'b00, 0, 0, 2'b00);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            vectors++;
            if (obs[0] !== exp) begin
                miscompares++; $display("FAIL no_regrant cycle%0d: got %h expected %h", k, obs[0], exp);
            end
        end
        U_REQ = 0; tick();
        U_REQ = 1; tick(); #1;
        exp = pack(0, 1, 23'h55, 16'h0, 2'b00, 0, 0, 2'b10);
        vectors++;
        if (obs[0] !== exp) begin
            miscompares++; $display("FAIL regrant_after_drop: got %h expected %h", obs[0], exp);
        end
        settle();
    endtask

    task automatic test_midop_reset();
        logic [46:0] exp;
        U_REQ = 1; U_ADDR = 23'h2AAAAA; U_OP = 2'b10;
        tick();
        BUSY = 1; tick();
        RST_N = 0; tick(); #1;
        exp = '0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp) begin
                miscompares++; $display("FAIL midop_reset dut%0d: got %h expected %h", k, obs[k], exp);
            end
        end
        RST_N = 1;
        settle();
    endtask

    task automatic test_no_timeout();
        logic [46:0] exp;
        U_REQ = 1;
        tick();
        exp = pack(0, 1, 23'h0, 16'h0, 2'b00, 0, 0, 2'b10);
        for (int i = 0; i < 500; i++) begin
            tick(); #1;
            vectors++;
            if (obs[1] !== exp) begin
                miscompares++; $display("FAIL no_timeout cycle%0d: got %h expected %h", i, obs[1], exp);
            end
        end
        settle();
    endtask

    task automatic test_random();
        logic [46:0] exp;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) A_REQ = ~A_REQ;
            if ($urandom_range(7) == 0) U_REQ = ~U_REQ;
            A_EXECUTE  = ($urandom_range(2) == 0);
            U_EXECUTE  = ($urandom_range(2) == 0);
            BUSY       = ($urandom_range(2) == 0);
            A_ADDR     = 23'($urandom);
            U_ADDR     = 23'($urandom);
            A_CMD_DATA = 16'($urandom);
            U_CMD_DATA = 16'($urandom);
            A_OP       = 2'($urandom);
            U_OP       = 2'($urandom);
            RST_N      = ($urandom_range(199) != 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                exp = mdl_out(m[k]);
                vectors++;
                if (obs[k] !== exp) begin
                    miscompares++;
                    $display("FAIL random dut%0d step%0d: got %h expected %h", k, i, obs[k], exp);
                end
            end
            vectors++;
            if (d8_a_gnt && d8_u_gnt) begin
                miscompares++; $display("FAIL dual_grant step%0d: got 11 expected not both", i);
            end
            tick();
        end
        RST_N = 1;
        settle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        RST_N = 0;
        clear_inputs();
        test_reset();
        test_autoload();
        test_arbitration();
        test_exec_gating();
        test_watchdog();
        test_midop_reset();
        test_no_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
